// File: rtl/cache_req_arbiter.sv
// Round-robin arbiter sharing one cache controller CPU port among NUM_REQ requesters.
// Optional watchdog enabled by defining ARB_TIMEOUT_EN.
module cache_req_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ-1:0]         req_rw,
  input  logic [NUM_REQ*32-1:0]      req_addr,
  input  logic [NUM_REQ*128-1:0]     req_datain,
  output logic [NUM_REQ-1:0]         req_ack,
  output logic [31:0]                resp_data,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic                       busy,
  output logic                       timeout_err,
  output logic [31:0]                cpu_req_addr,
  output logic [127:0]               cpu_req_datain,
  output logic                       cpu_req_rw,
  output logic                       cpu_req_valid,
  input  logic [31:0]                cpu_req_dataout,
  input  logic                       cache_ready
);

  localparam int unsigned IdW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e         state_q, state_d;
  logic [IdW-1:0] ptr_q, ptr_d, gnt_q, gnt_d;
  logic           seen_low_q, seen_low_d;

  logic [NUM_REQ-1:0] req_ack_q, req_ack_d;
  logic [31:0]        resp_data_q, resp_data_d;
  logic [IdW-1:0]     resp_id_q, resp_id_d;
  logic               busy_q, busy_d;
  logic               timeout_err_q, timeout_err_d;
  logic [31:0]        addr_q, addr_d;
  logic [127:0]       datain_q, datain_d;
  logic               rw_q, rw_d;
  logic               valid_q, valid_d;

  logic           any_req;
  logic [IdW-1:0] win_id, sel;
  logic [31:0]    win_addr;
  logic [127:0]   win_datain;
  logic           win_rw;
  logic           wd_expire;

  // First requesting index at or after ptr, wrapping.
  always_comb begin
    any_req = 1'b0;
    win_id  = '0;
    sel     = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      sel = IdW'((32'(ptr_q) + k) % NUM_REQ);
      if (!any_req && req_valid[sel]) begin
        any_req = 1'b1;
        win_id  = sel;
      end
    end
  end

  always_comb begin
    win_addr   = '0;
    win_datain = '0;
    win_rw     = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (win_id == IdW'(i)) begin
        win_addr   = req_addr[i*32 +: 32];
        win_datain = req_datain[i*128 +: 128];
        win_rw     = req_rw[i];
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int unsigned CntW = (TIMEOUT > 255) ? 16 : 8;

  logic [CntW-1:0] wd_q, wd_d;

  assign wd_expire = (wd_q + 1'b1) == CntW'(TIMEOUT);

  always_comb begin
    wd_d = wd_q;
    if (state_q == StIssue) begin
      wd_d = '0;
    end else if (state_q == StWait) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign wd_expire = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    gnt_d         = gnt_q;
    seen_low_d    = seen_low_q;
    req_ack_d     = '0;
    timeout_err_d = 1'b0;
    resp_data_d   = resp_data_q;
    resp_id_d     = resp_id_q;
    busy_d        = busy_q;
    addr_d        = addr_q;
    datain_d      = datain_q;
    rw_d          = rw_q;
    valid_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_req && cache_ready) begin
          addr_d   = win_addr;
          datain_d = win_datain;
          rw_d     = win_rw;
          valid_d  = 1'b1;
          busy_d   = 1'b1;
          gnt_d    = win_id;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        seen_low_d = 1'b0;
        state_d    = StWait;
      end
      StWait: begin
        if (!cache_ready) begin
          seen_low_d = 1'b1;
        end
        // Completion needs ready to have dropped first; the issue cycle still shows it high.
        if (cache_ready && seen_low_q) begin
          resp_data_d = cpu_req_dataout;
          resp_id_d   = gnt_q;
          req_ack_d   = NUM_REQ'(1) << gnt_q;
          busy_d      = 1'b0;
          ptr_d       = (gnt_q == IdW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
          state_d     = StIdle;
        end else if (wd_expire) begin
          resp_data_d   = '0;
          resp_id_d     = gnt_q;
          req_ack_d     = NUM_REQ'(1) << gnt_q;
          timeout_err_d = 1'b1;
          busy_d        = 1'b0;
          ptr_d         = (gnt_q == IdW'(NUM_REQ - 1)) ? '0 : gnt_q + 1'b1;
          state_d       = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      ptr_q         <= '0;
      gnt_q         <= '0;
      seen_low_q    <= 1'b0;
      req_ack_q     <= '0;
      resp_data_q   <= '0;
      resp_id_q     <= '0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      addr_q        <= '0;
      datain_q      <= '0;
      rw_q          <= 1'b0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      gnt_q         <= gnt_d;
      seen_low_q    <= seen_low_d;
      req_ack_q     <= req_ack_d;
      resp_data_q   <= resp_data_d;
      resp_id_q     <= resp_id_d;
      busy_q        <= busy_d;
      timeout_err_q <= timeout_err_d;
      addr_q        <= addr_d;
      datain_q      <= datain_d;
      rw_q          <= rw_d;
      valid_q       <= valid_d;
    end
  end

  assign req_ack        = req_ack_q;
  assign resp_data      = resp_data_q;
  assign resp_id        = resp_id_q;
  assign busy           = busy_q;
  assign timeout_err    = timeout_err_q;
  assign cpu_req_addr   = addr_q;
  assign cpu_req_datain = datain_q;
  assign cpu_req_rw     = rw_q;
  assign cpu_req_valid  = valid_q;

endmodule

// File: tb/tb_cache_req_arbiter.sv
// Bench for cache_req_arbiter: directed vector table, corner sequences and a randomized
// run against a transaction-level model. Watchdog checks follow ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module tb_cache_req_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned TO = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     req_valid, req_rw, req_ack;
  logic [N*32-1:0]  req_addr;
  logic [N*128-1:0] req_datain;
  logic [31:0]      resp_data, cpu_req_addr, cpu_req_dataout;
  logic [1:0]       resp_id;
  logic             busy, timeout_err, cpu_req_rw, cpu_req_valid, cache_ready;
  logic [127:0]     cpu_req_datain;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  cache_req_arbiter #(.NUM_REQ(N), .TIMEOUT(TO)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_rw          (req_rw),
    .req_addr        (req_addr),
    .req_datain      (req_datain),
    .req_ack         (req_ack),
    .resp_data       (resp_data),
    .resp_id         (resp_id),
    .busy            (busy),
    .timeout_err     (timeout_err),
    .cpu_req_addr    (cpu_req_addr),
    .cpu_req_datain  (cpu_req_datain),
    .cpu_req_rw      (cpu_req_rw),
    .cpu_req_valid   (cpu_req_valid),
    .cpu_req_dataout (cpu_req_dataout),
    .cache_ready     (cache_ready)
  );

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  // Simple cache controller: ready drops after a request for next_lat cycles.
  int unsigned next_lat;
  bit          stall;
  int unsigned low_left;
  logic [31:0] lat_addr;
  logic        lat_rw;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_ready     <= 1'b1;
      low_left        <= 0;
      cpu_req_dataout <= '0;
      lat_addr        <= '0;
      lat_rw          <= 1'b0;
    end else if (cpu_req_valid) begin
      cache_ready <= 1'b0;
      low_left    <= next_lat - 1;
      lat_addr    <= cpu_req_addr;
      lat_rw      <= cpu_req_rw;
    end else if (!cache_ready && !stall) begin
      if (low_left == 0) begin
        cache_ready <= 1'b1;
        if (!lat_rw) cpu_req_dataout <= word_of(lat_addr);
      end else begin
        low_left <= low_left - 1;
      end
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] all_outs();
    return {req_ack, resp_data, resp_id, busy, timeout_err, cpu_req_addr, cpu_req_datain,
            cpu_req_rw, cpu_req_valid};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ack(output int unsigned n);
    n = 0;
    do begin
      tick();
      n++;
    end while (req_ack == '0 && n < 40);
  endtask

  task automatic set_payloads();
    req_addr = {32'h3C, 32'h10, 32'h100, 32'h40};
    req_rw   = '0;
    for (int i = 0; i < N; i++) req_datain[i*128 +: 128] = {4{32'hD000_0000 + i}};
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    stall     = 1'b0;
    next_lat  = 1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  typedef struct {
    logic [N-1:0] req;
    int unsigned  lat;
    logic [N-1:0] exp_ack;
    logic [31:0]  exp_addr;
  } vec_t;

  vec_t        tbl[8];
  int unsigned n;
  int          k;

  // Randomized-phase model state
  bit               m_busy, found;
  int unsigned      m_ptr, m_gnt, m_ack_at, w, pre_lat;
  logic [31:0]      m_addr;
  logic [127:0]     m_din;
  logic             m_rw, pre_ready, exp_valid;
  logic [N-1:0]     pre_req, pre_rw, exp_ack;
  logic [N*32-1:0]  pre_addr;
  logic [N*128-1:0] pre_din;

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // Winners follow the pointer left by each previous vector, starting from 0.
    tbl[0] = '{4'b0100, 1, 4'b0100, 32'h10};
    tbl[1] = '{4'b0101, 1, 4'b0001, 32'h40};
    tbl[2] = '{4'b0101, 5, 4'b0100, 32'h10};
    tbl[3] = '{4'b1111, 1, 4'b1000, 32'h3C};
    tbl[4] = '{4'b1000, 2, 4'b1000, 32'h3C};
    tbl[5] = '{4'b0010, 1, 4'b0010, 32'h100};
    tbl[6] = '{4'b0011, 6, 4'b0001, 32'h40};
    tbl[7] = '{4'b1110, 1, 4'b0010, 32'h100};

    rst = 1'b0;
    req_valid = '0;
    req_rw = '0;
    req_addr = '0;
    req_datain = '0;
    stall = 1'b0;
    next_lat = 1;
    #2 rst = 1'b1;
    #1 check("reset_outputs", all_outs(), '0);
    set_payloads();
    tick();
    tick();
    rst = 1'b0;
    tick();

    for (int v = 0; v < 8; v++) begin
      next_lat  = tbl[v].lat;
      req_valid = tbl[v].req;
      tick();
      check("tbl_grant_valid", cpu_req_valid, 1);
      check("tbl_grant_busy", busy, 1);
      check("tbl_grant_addr", cpu_req_addr, tbl[v].exp_addr);
      wait_ack(n);
      check("tbl_ack_latency", n, tbl[v].lat + 2);
      check("tbl_ack", req_ack, tbl[v].exp_ack);
      check("tbl_resp_id", resp_id, $clog2(tbl[v].exp_ack));
      check("tbl_resp_data", resp_data, word_of(tbl[v].exp_addr));
      check("tbl_ack_busy", busy, 0);
      req_valid = '0;
      tick();
      check("tbl_ack_pulse", req_ack, 0);
    end

    // Reset in WAIT: pointer is 2 here, requester 3 is granted, then abandoned.
    stall = 1'b1;
    req_valid = 4'b1000;
    tick();
    tick();
    tick();
    tick();
    check("rstw_busy_before", busy, 1);
    #3 rst = 1'b1;
    #1 check("rstw_async_outputs", all_outs(), '0);
    tick();
    check("rstw_no_ack", req_ack, 0);
    stall = 1'b0;
    rst = 1'b0;
    req_valid = '1;
    next_lat = 1;
    tick();
    check("rstw_regrant_valid", cpu_req_valid, 1);
    check("rstw_regrant_addr", cpu_req_addr, 32'h40);
    wait_ack(n);
    check("rstw_regrant_ack", req_ack, 4'b0001);
    req_valid = '0;
    tick();

    // Round robin with all requesters held high.
    do_reset();
    req_valid = '1;
    k = 0;
    n = 0;
    while (k < 5 && n < 100) begin
      tick();
      n++;
      if (req_ack != '0) begin
        check("rr_ack_order", req_ack, 4'b0001 << (k % 4));
        check("rr_no_grant_in_ack", cpu_req_valid, 0);
        k++;
        if (k == 5) begin
          req_valid = '0;
        end else begin
          tick();
          n++;
          check("rr_next_grant", cpu_req_valid, 1);
        end
      end
    end
    check("rr_count", k, 5);
    tick();

    // Payload capture: requester 1 changes its address after grant.
    next_lat = 3;
    req_valid = 4'b0010;
    tick();
    check("cap_valid", cpu_req_valid, 1);
    check("cap_addr_grant", cpu_req_addr, 32'h100);
    tick();
    req_addr[32 +: 32] = 32'h200;
    n = 1;
    while (req_ack == '0 && n < 40) begin
      tick();
      n++;
      check("cap_addr_hold", cpu_req_addr, 32'h100);
    end
    check("cap_ack", req_ack, 4'b0010);
    check("cap_data", resp_data, word_of(32'h100));
    req_valid = '0;
    req_addr[32 +: 32] = 32'h100;
    tick();

    // Cache never completes: pointer is 2, so requester 2 wins.
    stall = 1'b1;
    req_valid = 4'b0100;
    tick();
    tick();
`ifdef ARB_TIMEOUT_EN
    for (int j = 1; j < 16; j++) begin
      tick();
      check("wd_quiet", {req_ack, timeout_err}, 0);
    end
    tick();
    check("wd_timeout_err", timeout_err, 1);
    check("wd_ack", req_ack, 4'b0100);
    check("wd_resp_data", resp_data, 0);
    check("wd_busy", busy, 0);
    req_valid = '0;
    stall = 1'b0;
    tick();
    check("wd_err_pulse", timeout_err, 0);
`else
    for (int j = 0; j < 40; j++) begin
      tick();
      check("nowd_no_ack", {req_ack, timeout_err}, 0);
    end
`endif

    // Randomized traffic against the transaction-level model.
    do_reset();
    m_busy = 1'b0;
    m_ptr = 0;
    for (int c = 0; c < 3000; c++) begin
      req_valid = req_valid & ~req_ack;
      if (!m_busy) next_lat = ($urandom_range(0, 3) == 0) ? $urandom_range(3, 8) : 1;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          req_rw[i] = 1'($urandom_range(0, 1));
          req_addr[i*32 +: 32] = $urandom & 32'hFFFF_FFFC;
          req_datain[i*128 +: 128] = {$urandom, $urandom, $urandom, $urandom};
        end
      end
      if (m_busy && $urandom_range(0, 1) == 1) req_addr[m_gnt*32 +: 32] = $urandom;
      pre_req = req_valid;
      pre_ready = cache_ready;
      pre_addr = req_addr;
      pre_din = req_datain;
      pre_rw = req_rw;
      pre_lat = next_lat;
      tick();
      exp_valid = 1'b0;
      exp_ack = '0;
      if (m_busy) begin
        if (c == int'(m_ack_at)) begin
          exp_ack[m_gnt] = 1'b1;
          m_busy = 1'b0;
          m_ptr = (m_gnt + 1) % N;
        end
      end else if (pre_req != '0 && pre_ready) begin
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
          w = (m_ptr + j) % N;
          if (!found && pre_req[w]) begin
            found = 1'b1;
            m_gnt = w;
          end
        end
        m_busy = 1'b1;
        exp_valid = 1'b1;
        m_addr = pre_addr[m_gnt*32 +: 32];
        m_din = pre_din[m_gnt*128 +: 128];
        m_rw = pre_rw[m_gnt];
        m_ack_at = c + pre_lat + 2;
      end
      check("rnd_valid", cpu_req_valid, exp_valid);
      if (exp_valid) check("rnd_payload", {cpu_req_addr, cpu_req_datain, cpu_req_rw},
                           {m_addr, m_din, m_rw});
      check("rnd_ack", req_ack, exp_ack);
      check("rnd_busy", busy, m_busy);
      check("rnd_timeout_err", timeout_err, 0);
      if (exp_ack != '0) begin
        check("rnd_resp_id", resp_id, m_gnt);
        if (!m_rw) check("rnd_resp_data", resp_data, word_of(m_addr));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
